parity_check_arbiter: RTL and testbench

Shares one even-parity check datapath among NUM_REQ requesters. Each requester presents a DATA_W-bit word and its parity bit. Arbitration is round-robin, and each checked word returns a registered error flag tagged with the requester id. The block also keeps a saturating error counter per requester, which status/CSR logic reads. It sits between the per-lane parity sources and the error-reporting logic.

---
 rtl/parity_check_arbiter.sv | 126 ++++++++++++
 tb/tb_parity_check_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_check_arbiter.sv
// Round-robin arbiter sharing one even-parity checker among NUM_REQ lanes.
// Results sit in a one-entry output register, and errors are counted per lane.
module parity_check_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 4,
   parameter int CNT_W   = 8,
   parameter int ID_W    = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_parity,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [ID_W-1:0]           resp_id,
   output logic                      resp_error,
   input  logic                      cnt_clear,
   output logic [NUM_REQ*CNT_W-1:0]  err_cnt,
   output logic                      dbg_full
);

   // Handshakes: a word or result moves on any cycle where valid && ready;
   // valid never waits on ready, and ready is never a function of the payload.
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t                         state_q, state_d;
   logic [ID_W-1:0]                ptr_q, ptr_d;
   logic [ID_W-1:0]                id_q, id_d;
   logic                           err_q, err_d;
   logic [NUM_REQ-1:0][CNT_W-1:0]  cnt_q, cnt_d;

   logic                           issue_ok;
   logic [NUM_REQ-1:0]             grant;
   logic [ID_W-1:0]                grant_id;
   logic [ID_W-1:0]                idx;
   logic                           found;
   logic                           grant_err;
   logic                           count_inc;

   assign issue_ok = (state_q == EMPTY) || resp_ready;

   // Search starts one past the last winner and wraps around.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      idx      = '0;
      found    = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
         if (!found && req_valid[idx]) begin
            found       = 1'b1;
            grant[idx]  = 1'b1;
            grant_id    = idx;
         end
      end
      if (!issue_ok || !rst_n) begin
         grant    = '0;
         grant_id = '0;
      end
   end

   always_comb begin
      grant_err = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_err = grant_err |
                     (grant[i] & ((^req_data[i*DATA_W +: DATA_W]) ^ req_parity[i]));
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      err_d   = err_q;
      if (issue_ok) begin
         if (|grant) begin
            state_d = FULL;
            ptr_d   = grant_id;
            id_d    = grant_id;
            err_d   = grant_err;
         end else begin
            state_d = EMPTY;
         end
      end
   end

   assign count_inc = (state_q == FULL) && resp_ready && err_q;

   // Clear takes priority over an increment landing in the same cycle.
   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (cnt_clear) begin
            cnt_d[i] = '0;
         end else if (count_inc && (id_q == ID_W'(i)) && (cnt_q[i] != '1)) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         ptr_q   <= ID_W'(NUM_REQ - 1);
         id_q    <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign req_ready  = grant;
   assign resp_valid = (state_q == FULL);
   assign resp_id    = id_q;
   assign resp_error = err_q;
   assign err_cnt    = cnt_q;
   assign dbg_full   = (state_q == FULL);

endmodule

// File: tb/tb_parity_check_arbiter.sv
// Bench for parity_check_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of arbitration and counting.
module tb_parity_check_arbiter;

   localparam int N  = 4;
   localparam int DW = 4;
   localparam int CW = 8;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_parity;
   logic [N-1:0]    req_ready;
   logic            resp_valid;
   logic            resp_ready;
   logic [IW-1:0]   resp_id;
   logic            resp_error;
   logic            cnt_clear;
   logic [N*CW-1:0] err_cnt;
   logic            dbg_full;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: pending result, last winner, counters as plain ints.
   bit m_valid;
   int m_id;
   bit m_err;
   int m_ptr;
   int m_cnt[N];

   always #5 clk = ~clk;

   parity_check_arbiter #(.NUM_REQ(N), .DATA_W(DW), .CNT_W(CW), .ID_W(IW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_parity (req_parity),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_error (resp_error),
      .cnt_clear  (cnt_clear),
      .err_cnt    (err_cnt),
      .dbg_full   (dbg_full)
   );

   function automatic int exp_winner();
      if (!rst_n || (m_valid && !resp_ready)) return -1;
      for (int k = 1; k <= N; k++) begin
         if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_ready();
      logic [N-1:0] r;
      int w;
      r = '0;
      w = exp_winner();
      if (w >= 0) r[w] = 1'b1;
      return r;
   endfunction

   function automatic logic [N*CW-1:0] exp_cnt();
      logic [N*CW-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) r[i*CW +: CW] = CW'(m_cnt[i]);
      return r;
   endfunction

   task automatic tick();
      int w;
      w = exp_winner();
      if (!rst_n) begin
         m_valid = 0; m_id = 0; m_err = 0; m_ptr = N - 1;
         for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else begin
         if (cnt_clear) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
         end else if (m_valid && resp_ready && m_err && m_cnt[m_id] < (1 << CW) - 1) begin
            m_cnt[m_id] = m_cnt[m_id] + 1;
         end
         if (!m_valid || resp_ready) begin
            if (w >= 0) begin
               m_valid = 1;
               m_id    = w;
               m_err   = ((($countones(req_data[w*DW +: DW]) + int'(req_parity[w])) % 2) == 1);
               m_ptr   = w;
            end else begin
               m_valid = 0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = '1; resp_ready = 1'b1; req_data = 16'hA5C3;
      #1;
      n_tests++;
      if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
      tick(); tick();
      n_tests++;
      if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", resp_valid); end
      n_tests++;
      if (resp_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d expected 0", resp_id); end
      n_tests++;
      if (resp_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", resp_error); end
      n_tests++;
      if (err_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %h expected 0", err_cnt); end
      rst_n = 1'b1; req_valid = '0;
   endtask

   task automatic test_single();
      req_valid = 4'b0100; req_data = 16'h0B00; req_parity = 4'b0100; resp_ready = 1'b0;
      #1;
      n_tests++;
      if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
      tick();
      req_valid = '0;
      n_tests++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_error !== 1'b0) begin
         n_fail++;
         $display("FAIL single_resp: got v=%b id=%0d e=%b expected v=1 id=2 e=0", resp_valid, resp_id, resp_error);
      end
      n_tests++;
      if (err_cnt !== '0) begin n_fail++; $display("FAIL single_cnt: got %h expected 0", err_cnt); end
   endtask

   task automatic test_error();
      resp_ready = 1'b1; req_valid = 4'b0010; req_data = 16'h0010; req_parity = 4'b0000;
      #1;
      n_tests++;
      if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL error_ready: got %b expected 0010", req_ready); end
      tick();
      req_valid = '0;
      n_tests++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_error !== 1'b1) begin
         n_fail++;
         $display("FAIL error_resp: got v=%b id=%0d e=%b expected v=1 id=1 e=1", resp_valid, resp_id, resp_error);
      end
      tick();
      n_tests++;
      if (err_cnt[1*CW +: CW] !== 8'd1) begin n_fail++; $display("FAIL error_cnt1: got %0d expected 1", err_cnt[1*CW +: CW]); end
      n_tests++;
      if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL error_drain: got %b expected 0", resp_valid); end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_g;
      do_reset();
      req_valid = '1; resp_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         req_data = 16'($urandom); req_parity = 4'($urandom);
         exp_g = '0;
         exp_g[k % N] = 1'b1;
         #1;
         n_tests++;
         if (req_ready !== exp_g) begin n_fail++; $display("FAIL rr_grant%0d: got %b expected %b", k, req_ready, exp_g); end
         tick();
         n_tests++;
         if (resp_valid !== 1'b1 || resp_id !== IW'(k % N) || resp_error !== m_err) begin
            n_fail++;
            $display("FAIL rr_resp%0d: got v=%b id=%0d e=%b expected v=1 id=%0d e=%b",
                     k, resp_valid, resp_id, resp_error, k % N, m_err);
         end
      end
   endtask

   task automatic test_stall();
      logic [IW-1:0] s_id;
      logic          s_err;
      s_id = resp_id; s_err = resp_error;
      resp_ready = 1'b0; req_valid = '1;
      for (int k = 0; k < 3; k++) begin
         req_data = 16'($urandom); req_parity = 4'($urandom);
         #1;
         n_tests++;
         if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready%0d: got %b expected 0000", k, req_ready); end
         tick();
         n_tests++;
         if (resp_valid !== 1'b1 || resp_id !== s_id || resp_error !== s_err) begin
            n_fail++;
            $display("FAIL stall_hold%0d: got v=%b id=%0d e=%b expected v=1 id=%0d e=%b",
                     k, resp_valid, resp_id, resp_error, s_id, s_err);
         end
      end
      resp_ready = 1'b1;
      #1;
      n_tests++;
      if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL stall_resume: got %b expected 0001", req_ready); end
      tick();
      n_tests++;
      if (resp_id !== 2'd0) begin n_fail++; $display("FAIL stall_resume_id: got %0d expected 0", resp_id); end
      req_valid = '0;
      tick();
   endtask

   task automatic test_saturate();
      do_reset();
      req_valid = 4'b1000; req_data = 16'h1000; req_parity = 4'b0000; resp_ready = 1'b1;
      repeat (260) tick();
      req_valid = '0;
      tick();
      n_tests++;
      if (err_cnt[3*CW +: CW] !== 8'd255) begin n_fail++; $display("FAIL sat_cnt3: got %0d expected 255", err_cnt[3*CW +: CW]); end
      req_valid = 4'b1000;
      tick();
      req_valid = '0; cnt_clear = 1'b1;
      #1;
      n_tests++;
      if (resp_valid !== 1'b1 || resp_error !== 1'b1) begin
         n_fail++; $display("FAIL clear_setup: got v=%b e=%b expected v=1 e=1", resp_valid, resp_error);
      end
      tick();
      cnt_clear = 1'b0;
      n_tests++;
      if (err_cnt !== '0) begin n_fail++; $display("FAIL clear_cnt: got %h expected 0", err_cnt); end
      n_tests++;
      if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL clear_handshake: got %b expected 0", resp_valid); end
      req_valid = 4'b1000;
      tick();
      req_valid = '0;
      tick();
      n_tests++;
      if (err_cnt[3*CW +: CW] !== 8'd1) begin n_fail++; $display("FAIL clear_recount: got %0d expected 1", err_cnt[3*CW +: CW]); end
   endtask

   task automatic test_reset_mid();
      resp_ready = 1'b0; req_valid = 4'b0010; req_data = 16'h0010; req_parity = 4'b0000;
      tick();
      req_valid = '0;
      n_tests++;
      if (resp_valid !== 1'b1 || resp_error !== 1'b1) begin
         n_fail++; $display("FAIL midrst_setup: got v=%b e=%b expected v=1 e=1", resp_valid, resp_error);
      end
      rst_n = 1'b0; resp_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      n_tests++;
      if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", resp_valid); end
      n_tests++;
      if (err_cnt !== '0) begin n_fail++; $display("FAIL midrst_cnt: got %h expected 0", err_cnt); end
      req_valid = '1;
      #1;
      n_tests++;
      if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_first: got %b expected 0001", req_ready); end
      tick();
      req_valid = '0;
      tick();
   endtask

   task automatic test_random();
      logic [N-1:0] er;
      for (int c = 0; c < 500; c++) begin
         rst_n      = ($urandom_range(0, 80) != 0);
         req_valid  = 4'($urandom);
         req_data   = 16'($urandom);
         req_parity = 4'($urandom);
         resp_ready = ($urandom_range(0, 3) != 0);
         cnt_clear  = ($urandom_range(0, 60) == 0);
         #1;
         er = exp_ready();
         n_tests++;
         if (req_ready !== er) begin n_fail++; $display("FAIL rand_ready@%0d: got %b expected %b", c, req_ready, er); end
         tick();
         n_tests++;
         if (resp_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid@%0d: got %b expected %b", c, resp_valid, m_valid); end
         if (m_valid) begin
            n_tests++;
            if (resp_id !== IW'(m_id) || resp_error !== m_err) begin
               n_fail++;
               $display("FAIL rand_resp@%0d: got id=%0d e=%b expected id=%0d e=%b", c, resp_id, resp_error, m_id, m_err);
            end
         end
         n_tests++;
         if (err_cnt !== exp_cnt()) begin n_fail++; $display("FAIL rand_cnt@%0d: got %h expected %h", c, err_cnt, exp_cnt()); end
      end
      rst_n = 1'b1; cnt_clear = 1'b0; req_valid = '0;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; req_data = '0; req_parity = '0;
      resp_ready = 1'b0; cnt_clear = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_error();
      test_round_robin();
      test_stall();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
